mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
- Producer side of the MAC operand interface: buffers signed operand pairs, then streams them into the MAC over a, b and valid_in.
- Collects the MAC's f/valid_out responses and reports the final accumulated value, a completion pulse and an error flag.
- Sits between the host/control logic and one MAC instance.
- Replaces hand-driven operand sequencing in the datapath.

Parameters:
- DEPTH, 16, number of operand-pair entries in the buffer (power of 2).
- AW, 4, log2(DEPTH).
- DW, 8, operand width (signed).
- FW, 16, MAC result width (signed).
- TIMEOUT, 15, max consecutive DRAIN cycles without valid_out before abort.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write one operand pair into buffer.
- wr_a  in  DW  signed operand A for write.
- wr_b  in  DW  signed operand B for write.
- full  out  1  buffer holds DEPTH entries.
- count  out  AW+1  entries currently loaded.
- start  in  1  begin streaming the loaded vector.
- busy  out  1  high in CLEAR/ISSUE/DRAIN.
- mac_clr  out  1  one-cycle pulse, integration ORs into MAC reset.
- a  out  DW  signed operand to MAC.
- b  out  DW  signed operand to MAC.
- valid_in  out  1  operand pair valid to MAC.
- f  in  FW  signed MAC accumulator output.
- valid_out  in  1  MAC result valid.
- result  out  FW  last captured f.
- result_valid  out  1  result holds final value of completed run.
- done  out  1  one-cycle completion pulse.
- err  out  1  run ended by timeout; sticky until next start.

Behaviour:
- Reset (sync, active-high):
  - all outputs to 0: a, b, valid_in, mac_clr, busy, done, err, result, result_valid, full, count.
  - State to IDLE; wr/rd pointers and issue/receive counters cleared.
  - Reset mid-run aborts immediately and empties the buffer.
- Buffer writes:
  - Accepted only in IDLE with count<DEPTH.
  - wr_en while full or not IDLE is dropped silently; count unchanged.
  - full = (count==DEPTH), registered with count.
- States:
  - IDLE:
    - start=1 and count>0 -> CLEAR.
    - start with count==0 is ignored.
    - start outside IDLE is ignored.
  - CLEAR (1 cycle):
    - mac_clr=1, busy=1.
    - Clears result, result_valid and err.
    - -> ISSUE.
  - ISSUE:
    - Each cycle: a/b = buffer[rd_ptr], valid_in=1, rd_ptr++, issued++.
    - After issued==count -> DRAIN.
    - First valid_in is the cycle after mac_clr.
  - DRAIN:
    - a=b=0, valid_in=0.
    - Timeout counter increments each cycle without valid_out and resets on valid_out.
    - Counter reaching TIMEOUT -> DONE with err=1.
  - DONE (1 cycle):
    - done=1, busy=0, result_valid=1.
    - Buffer emptied (count=0, pointers 0).
    - -> IDLE.
    - result_valid and err hold until next CLEAR.
- Response collection:
  - In ISSUE and DRAIN, every valid_out captures f into result and increments received.
  - When received==count (checked on the valid_out cycle, from either state) -> DONE next cycle.
  - valid_out in IDLE, CLEAR or DONE is ignored.
  - valid_out arriving in the same cycle as the last issue counts normally.
- MAC latency is not assumed; any latency ≤ TIMEOUT cycles is tolerated.
- Arithmetic: no math in this block. f is captured as-is, sign preserved; result is full FW width.

Optional Feature:
- MAC_FEEDER_BUBBLE_EN
  - Defined: ISSUE inserts one bubble cycle (valid_in=0, a/b hold previous value, no rd_ptr advance) after every issued pair, including the last. A count of N issues in 2N cycles. Exercises the MAC's valid_in-low hold path.
  - Undefined: back-to-back issue, N pairs in N cycles.

Test Plan:
- Load (3,2), (-4,5), (-1,-1); start -> mac_clr one pulse, then 3 consecutive valid_in cycles with those pairs; done pulses; result=-13, result_valid=1, err=0, count=0.
- Write 17 pairs of (1,1) from reset -> full=1 after 16th write, 17th dropped, count=16; run -> result=16.
- start with empty buffer, then start asserted during ISSUE of a 4-pair run -> both ignored; single done; result matches the 4-pair sum.
- MAC valid_out tied low; load 2 pairs, start -> DRAIN lasts TIMEOUT=15 cycles; done=1, err=1, result_valid=1, result=0.
- Assert reset for 1 cycle during ISSUE of an 8-pair run -> next cycle all outputs 0, busy=0, count=0; fresh load of (-128,-128) yields result=16384.
- With MAC_FEEDER_BUBBLE_EN: 4 pairs (2,-3) -> valid_in pattern 1,0,1,0,1,0,1,0; result=-24.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// Operand feeder for one MAC: buffers signed pairs, streams them on a/b/valid_in, collects f/valid_out.
// Optional build macro MAC_FEEDER_BUBBLE_EN inserts one idle cycle after every issued pair.
module mac_operand_feeder #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned FW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic signed [DW-1:0] wr_a,
  input  logic signed [DW-1:0] wr_b,
  output logic                 full,
  output logic [AW:0]          count,
  input  logic                 start,
  output logic                 busy,
  output logic                 mac_clr,
  output logic signed [DW-1:0] a,
  output logic signed [DW-1:0] b,
  output logic                 valid_in,
  input  logic signed [FW-1:0] f,
  input  logic                 valid_out,
  output logic signed [FW-1:0] result,
  output logic                 result_valid,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
  } pair_t;

  pair_t mem [DEPTH];

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_d;
  logic [CW-1:0]  issued_q, issued_d;
  logic [CW-1:0]  received_q, received_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           mem_we;
  logic           resp;
  logic signed [DW-1:0] a_d, b_d;
  logic           valid_in_d, mac_clr_d, busy_d, done_d, err_d, result_valid_d;
  logic signed [FW-1:0] result_d;
`ifdef MAC_FEEDER_BUBBLE_EN
  logic           bub_q, bub_d;
`endif

  // Operand storage; contents are don't-care once count is zero.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= '{a: wr_a, b: wr_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      issued_q     <= '0;
      received_q   <= '0;
      tmo_q        <= '0;
      count        <= '0;
      full         <= 1'b0;
      a            <= '0;
      b            <= '0;
      valid_in     <= 1'b0;
      mac_clr      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
`ifdef MAC_FEEDER_BUBBLE_EN
      bub_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
      tmo_q        <= tmo_d;
      count        <= count_d;
      full         <= (count_d == CW'(DEPTH));
      a            <= a_d;
      b            <= b_d;
      valid_in     <= valid_in_d;
      mac_clr      <= mac_clr_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      result       <= result_d;
      result_valid <= result_valid_d;
`ifdef MAC_FEEDER_BUBBLE_EN
      bub_q        <= bub_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count;
    issued_d       = issued_q;
    received_d     = received_q;
    tmo_d          = tmo_q;
    mem_we         = 1'b0;
    a_d            = '0;
    b_d            = '0;
    valid_in_d     = 1'b0;
    mac_clr_d      = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    err_d          = err;
    result_d       = result;
    result_valid_d = result_valid;
    resp           = valid_out && ((state_q == ISSUE) || (state_q == DRAIN));
`ifdef MAC_FEEDER_BUBBLE_EN
    bub_d          = bub_q;
`endif

    case (state_q)
      IDLE: begin
        if (wr_en && (count < CW'(DEPTH))) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count + CW'(1);
        end
        if (start && (count != '0)) state_d = CLEAR;
      end

      CLEAR: begin
        mac_clr_d      = 1'b1;
        busy_d         = 1'b1;
        result_d       = '0;
        result_valid_d = 1'b0;
        err_d          = 1'b0;
        rd_ptr_d       = '0;
        issued_d       = '0;
        received_d     = '0;
        tmo_d          = '0;
`ifdef MAC_FEEDER_BUBBLE_EN
        bub_d          = 1'b0;
`endif
        state_d        = ISSUE;
      end

      ISSUE: begin
        busy_d = 1'b1;
        tmo_d  = '0;
`ifdef MAC_FEEDER_BUBBLE_EN
        // Alternate issue / bubble; the bubble holds a/b so the MAC sees a stable bus.
        if (!bub_q) begin
          a_d        = mem[rd_ptr_q].a;
          b_d        = mem[rd_ptr_q].b;
          valid_in_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          issued_d   = issued_q + CW'(1);
          bub_d      = 1'b1;
        end else begin
          a_d   = a;
          b_d   = b;
          bub_d = 1'b0;
          if (issued_q == count) state_d = DRAIN;
        end
`else
        a_d        = mem[rd_ptr_q].a;
        b_d        = mem[rd_ptr_q].b;
        valid_in_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + AW'(1);
        issued_d   = issued_q + CW'(1);
        if (issued_d == count) state_d = DRAIN;
`endif
      end

      DRAIN: begin
        busy_d = 1'b1;
        if (valid_out) begin
          tmo_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end

      DONE: begin
        done_d         = 1'b1;
        result_valid_d = 1'b1;
        count_d        = '0;
        wr_ptr_d       = '0;
        rd_ptr_d       = '0;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Response capture wins over the issue/drain transitions once every pair is answered.
    if (resp) begin
      result_d   = f;
      received_d = received_q + CW'(1);
      if (received_d == count) state_d = DONE;
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder with a behavioural 1-cycle-latency MAC and result/operand scoreboards.
module tb_mac_operand_feeder;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned FW      = 16;
  localparam int unsigned TIMEOUT = 15;
`ifdef MAC_FEEDER_BUBBLE_EN
  localparam int BUB = 2;
`else
  localparam int BUB = 1;
`endif

  logic clk = 1'b0;
  logic reset, wr_en, start, valid_out, mute;
  logic signed [DW-1:0] wr_a, wr_b, a, b;
  logic signed [FW-1:0] f, result;
  logic full, busy, mac_clr, valid_in, result_valid, done, err;
  logic [AW:0] count;

  mac_operand_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .FW(FW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .full(full),
    .count(count), .start(start), .busy(busy), .mac_clr(mac_clr), .a(a), .b(b),
    .valid_in(valid_in), .f(f), .valid_out(valid_out), .result(result),
    .result_valid(result_valid), .done(done), .err(err));

  always #5 clk = ~clk;

  // Behavioural MAC: accumulates a*b, answers one cycle after valid_in unless muted.
  logic signed [FW-1:0] acc, pa, pb;
  assign pa = a;
  assign pb = b;
  assign f  = acc;
  always_ff @(posedge clk) begin
    if (reset || mac_clr) begin
      acc       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in && !mute;
      if (valid_in) acc <= acc + pa * pb;
    end
  end

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;
  typedef struct packed {
    logic signed [FW-1:0] res;
    logic                 err;
  } exp_t;
  typedef struct packed {
    logic [3:0]           n;
    logic [7:0][DW-1:0]   va;
    logic [7:0][DW-1:0]   vb;
    logic                 mute;
    logic signed [FW-1:0] exp_res;
    logic                 exp_err;
  } vec_t;

  op_t  op_q[$];
  exp_t sb_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, clr_cnt = 0, vi_cnt = 0, busy_cnt = 0, done_cnt = 0;
  int clr_cyc = 0, first_vi = 0, last_vi = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: operand scoreboard on valid_in, result scoreboard on done.
  always @(negedge clk) begin
    op_t  o;
    exp_t e;
    cyc++;
    if (!reset) begin
      if (busy) busy_cnt++;
      if (mac_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (valid_in) begin
        vi_cnt++;
        if (vi_cnt == 1) first_vi = cyc;
        last_vi = cyc;
        if (op_q.size() == 0) chk("op_unexpected", 1, 0);
        else begin
          o = op_q.pop_front();
          chk("op_a", int'(a), int'($signed(o.a)));
          chk("op_b", int'(b), int'($signed(o.b)));
        end
      end
      if (done) begin
        done_cnt++;
        if (sb_q.size() == 0) chk("sb_unexpected_done", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("sb_result", int'(result), int'(e.res));
          chk("sb_err", int'(err), int'(e.err));
          chk("sb_result_valid", int'(result_valid), 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pair(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y,
                            input bit accept);
    wr_en = 1'b1; wr_a = x; wr_b = y;
    tick();
    wr_en = 1'b0;
    if (accept) op_q.push_back('{a: x, b: y});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, int'(a), 0);
    chk({tag, "_b"}, int'(b), 0);
    chk({tag, "_valid_in"}, int'(valid_in), 0);
    chk({tag, "_mac_clr"}, int'(mac_clr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_count"}, int'(count), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done) got = 1;
    end
    chk("done_seen", int'(got), 1);
  endtask

  // Starts a run of n loaded pairs and checks stream shape and final state.
  task automatic do_run(input int n, input int exp_res, input bit exp_err, input bit muted);
    clr_cnt = 0; vi_cnt = 0; busy_cnt = 0;
    mute = muted;
    sb_q.push_back('{res: FW'(exp_res), err: exp_err});
    pulse_start();
    wait_done(200);
    chk("run_count", int'(count), 0);
    chk("run_full", int'(full), 0);
    chk("run_busy", int'(busy), 0);
    chk("run_result_valid", int'(result_valid), 1);
    chk("run_mac_clr_pulses", clr_cnt, 1);
    chk("run_valid_in_cnt", vi_cnt, n);
    chk("run_first_vi_gap", first_vi - clr_cyc, 1);
    chk("run_vi_span", last_vi - first_vi, BUB * (n - 1));
    if (muted) chk("run_busy_cycles", busy_cnt, 1 + BUB * n + int'(TIMEOUT));
    tick();
    chk("run_done_pulse", int'(done), 0);
    chk("run_err_hold", int'(err), int'(exp_err));
    mute = 1'b0;
  endtask

  task automatic add_pair(inout vec_t v, input int x, input int y);
    v.va[v.n] = DW'(x);
    v.vb[v.n] = DW'(y);
    v.n       = v.n + 4'd1;
  endtask

  vec_t vecs[5];

  initial begin
    int d0;
    for (int i = 0; i < 5; i++) vecs[i] = '0;
    add_pair(vecs[0], 3, 2); add_pair(vecs[0], -4, 5); add_pair(vecs[0], -1, -1);
    vecs[0].exp_res = FW'(-13);
    add_pair(vecs[1], -128, -128);
    vecs[1].exp_res = FW'(16384);
    for (int i = 0; i < 4; i++) add_pair(vecs[2], 2, -3);
    vecs[2].exp_res = FW'(-24);
    add_pair(vecs[3], 1, 1); add_pair(vecs[3], 1, 1);
    vecs[3].mute = 1'b1; vecs[3].exp_res = '0; vecs[3].exp_err = 1'b1;
    add_pair(vecs[4], 127, 127); add_pair(vecs[4], 127, -128);
    vecs[4].exp_res = FW'(-127);

    reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_a = '0; wr_b = '0; mute = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_zero("reset");

    // Fill past capacity: 17th write dropped.
    for (int i = 0; i < 15; i++) write_pair(8'sd1, 8'sd1, 1'b1);
    chk("fill15_full", int'(full), 0);
    chk("fill15_count", int'(count), 15);
    write_pair(8'sd1, 8'sd1, 1'b1);
    chk("fill16_full", int'(full), 1);
    chk("fill16_count", int'(count), 16);
    write_pair(8'sd1, 8'sd1, 1'b0);
    chk("fill17_full", int'(full), 1);
    chk("fill17_count", int'(count), 16);
    do_run(16, 16, 1'b0, 1'b0);

    // Empty start ignored; start and write during ISSUE ignored.
    d0 = done_cnt;
    pulse_start();
    tick(); tick();
    chk("empty_start_busy", int'(busy), 0);
    write_pair(8'sd5, 8'sd6, 1'b1); write_pair(-8'sd7, 8'sd3, 1'b1);
    write_pair(8'sd2, 8'sd2, 1'b1); write_pair(-8'sd1, 8'sd8, 1'b1);
    sb_q.push_back('{res: FW'(5), err: 1'b0});
    pulse_start();
    tick();
    pulse_start();
    write_pair(8'sd9, 8'sd9, 1'b0);
    chk("busy_write_dropped", int'(count), 4);
    wait_done(200);
    repeat (20) tick();
    chk("single_done", done_cnt - d0, 1);
    chk("after_run_busy", int'(busy), 0);

    // Reset during ISSUE of an 8-pair run.
    for (int i = 0; i < 8; i++) write_pair(8'sd1, 8'sd2, 1'b1);
    sb_q.push_back('{res: FW'(16), err: 1'b0});
    pulse_start();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    op_q.delete();
    sb_q.delete();
    check_zero("midrun_reset");

    // Table-driven runs.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) write_pair(vecs[v].va[i], vecs[v].vb[i], 1'b1);
      do_run(int'(vecs[v].n), int'(vecs[v].exp_res), vecs[v].exp_err, vecs[v].mute);
    end

    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 0);
    chk("op_drained", op_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
